// File: rtl/eight2four.sv
// eight2four: byte-to-nibble serializer.
// Each accepted byte is emitted as two nibbles, high first, on a
// valid/ready output. A one-byte hold register feeds the output and a
// one-byte pending buffer absorbs the next byte so that back-to-back bytes
// stream at one nibble per cycle.
//
// Handshake: a byte is accepted on a rising edge where DATA_VALID=1 and
// IN_READY=1. A nibble transfers on a rising edge where OUTPUT_VALID=1 and
// OUT_READY=1. DATA_VALID while IN_READY=0 discards the byte and sets the
// sticky DROPPED flag. OUT_READY is don't-care while OUTPUT_VALID=0.
module eight2four (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_VALID,
    input  logic [7:0] DATA_IN,
    output logic       IN_READY,
    input  logic       OUT_READY,
    output logic       OUTPUT_VALID,
    output logic [3:0] DATA_OUT,
    output logic       NIBBLE_SEL,
    output logic       DROPPED,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;

    // Byte currently being emitted and the queued follower.
    logic [7:0] hold;
    logic [7:0] hold_n;
    logic [7:0] pend;
    logic [7:0] pend_n;
    logic       pend_valid;
    logic       pend_valid_n;

    // Registered-output next values.
    logic       in_ready_n;
    logic       output_valid_n;
    logic [3:0] data_out_n;
    logic       nibble_sel_n;
    logic       dropped_n;

    // Handshake events on this edge.
    logic       accept;
    logic       transfer;
    logic       overrun;

    assign accept   = DATA_VALID && IN_READY;
    assign transfer = OUTPUT_VALID && OUT_READY;
    assign overrun  = DATA_VALID && !IN_READY;

    assign fsm_state = state;

    // Next-state, storage and registered-output computation.
    always_comb begin
        state_n      = state;
        hold_n       = hold;
        pend_n       = pend;
        pend_valid_n = pend_valid;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    hold_n  = DATA_IN;
                    state_n = HIGH;
                end
            end

            HIGH: begin
                if (transfer) begin
                    state_n = LOW;
                end
                if (accept) begin
                    pend_n       = DATA_IN;
                    pend_valid_n = 1'b1;
                end
            end

            LOW: begin
                if (transfer) begin
                    if (pend_valid) begin
                        // IN_READY is low whenever pending is full, so no
                        // accept can coincide with this branch.
                        hold_n       = pend;
                        pend_valid_n = 1'b0;
                        state_n      = HIGH;
                    end else if (accept) begin
                        // Bypass the pending buffer: the byte arriving as the
                        // low nibble leaves goes straight into hold.
                        hold_n  = DATA_IN;
                        state_n = HIGH;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    pend_n       = DATA_IN;
                    pend_valid_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n     = !pend_valid_n;
        output_valid_n = (state_n != IDLE);
        nibble_sel_n   = (state_n == HIGH);
        dropped_n      = DROPPED || overrun;

        data_out_n = 4'h0;
        if (state_n == HIGH) begin
            data_out_n = hold_n[7:4];
        end else if (state_n == LOW) begin
            data_out_n = hold_n[3:0];
        end
    end

    // State, storage and output registers; reset wins over every event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            hold         <= 8'h00;
            pend         <= 8'h00;
            pend_valid   <= 1'b0;
            IN_READY     <= 1'b1;
            OUTPUT_VALID <= 1'b0;
            DATA_OUT     <= 4'h0;
            NIBBLE_SEL   <= 1'b0;
            DROPPED      <= 1'b0;
        end else begin
            state        <= state_n;
            hold         <= hold_n;
            pend         <= pend_n;
            pend_valid   <= pend_valid_n;
            IN_READY     <= in_ready_n;
            OUTPUT_VALID <= output_valid_n;
            DATA_OUT     <= data_out_n;
            NIBBLE_SEL   <= nibble_sel_n;
            DROPPED      <= dropped_n;
        end
    end

endmodule

// File: tb/tb_eight2four.sv
// Testbench for eight2four: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// byte-queue model of the serializer.
module tb_eight2four;

  logic       clk;
  logic       reset;
  logic       data_valid;
  logic [7:0] data_in;
  logic       in_ready;
  logic       out_ready;
  logic       output_valid;
  logic [3:0] data_out;
  logic       nibble_sel;
  logic       dropped;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  eight2four dut (
    .CLK          (clk),
    .RESET        (reset),
    .DATA_VALID   (data_valid),
    .DATA_IN      (data_in),
    .IN_READY     (in_ready),
    .OUT_READY    (out_ready),
    .OUTPUT_VALID (output_valid),
    .DATA_OUT     (data_out),
    .NIBBLE_SEL   (nibble_sel),
    .DROPPED      (dropped),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model ----------------
  // exp_q holds every accepted byte not yet fully emitted; the head is the
  // byte on the output, half tells which nibble of it is showing.
  logic [7:0] exp_q[$];
  bit         half    = 1'b0;
  bit         m_drop  = 1'b0;
  bit         started = 1'b0;

  function automatic bit m_ready();
    return exp_q.size() < 2;
  endfunction

  function automatic bit m_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic [3:0] m_data();
    logic [7:0] b;
    if (exp_q.size() == 0) return 4'h0;
    b = exp_q[0];
    return half ? b[3:0] : b[7:4];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the pre-edge model view.
  always @(posedge clk) begin
    bit rdy;
    bit vld;
    rdy = m_ready();
    vld = m_valid();
    if (reset) begin
      exp_q.delete();
      half    = 1'b0;
      m_drop  = 1'b0;
      started = 1'b1;
    end else begin
      if (data_valid && !rdy) m_drop = 1'b1;
      if (vld && out_ready) begin
        if (!half) begin
          half = 1'b1;
        end else begin
          void'(exp_q.pop_front());
          half = 1'b0;
        end
      end
      if (data_valid && rdy) exp_q.push_back(data_in);
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      check("m_in_ready",     {7'd0, in_ready},     {7'd0, m_ready()});
      check("m_output_valid", {7'd0, output_valid}, {7'd0, m_valid()});
      check("m_data_out",     {4'd0, data_out},     {4'd0, m_data()});
      check("m_nibble_sel",   {7'd0, nibble_sel},   {7'd0, m_valid() && !half});
      check("m_dropped",      {7'd0, dropped},      {7'd0, m_drop});
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after an edge; outputs read then reflect it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit dv, input logic [7:0] din, input bit ordy);
    data_valid = dv;
    data_in    = din;
    out_ready  = ordy;
  endtask

  task automatic expect_out(input string name, input bit ov, input logic [3:0] d, input bit sel);
    check({name, "_valid"}, {7'd0, output_valid}, {7'd0, ov});
    check({name, "_data"},  {4'd0, data_out},     {4'd0, d});
    check({name, "_sel"},   {7'd0, nibble_sel},   {7'd0, sel});
  endtask

  task automatic expect_reset_state(input string name);
    expect_out(name, 1'b0, 4'h0, 1'b0);
    check({name, "_in_ready"}, {7'd0, in_ready}, 8'd1);
    check({name, "_dropped"},  {7'd0, dropped},  8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] stream[3];
    logic [3:0] got[7];
    bit         gotv[7];
    int         idx;
    bit         acc;

    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    expect_reset_state("reset");
    reset = 1'b0;

    // Single byte A5.
    drive(1'b1, 8'hA5, 1'b1);
    step();
    expect_out("a5_hi", 1'b1, 4'hA, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("a5_lo", 1'b1, 4'h5, 1'b0);
    step();
    check("a5_done", {7'd0, output_valid}, 8'd0);

    // Stream 12 34 56, offered whenever IN_READY=1.
    stream[0] = 8'h12;
    stream[1] = 8'h34;
    stream[2] = 8'h56;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      acc = (idx < 3) && in_ready;
      drive(acc, acc ? stream[idx] : 8'h00, 1'b1);
      step();
      if (acc) idx++;
      got[c]  = data_out;
      gotv[c] = output_valid;
    end
    for (int c = 0; c < 6; c++) begin
      check("stream_valid", {7'd0, gotv[c]}, 8'd1);
      check("stream_data",  {4'd0, got[c]},  8'(c + 1));
    end
    check("stream_end", {7'd0, gotv[6]}, 8'd0);

    // Backpressure: C3 held, 7E goes to pending.
    drive(1'b1, 8'hC3, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) step();
    expect_out("bp_hold", 1'b1, 4'hC, 1'b1);
    drive(1'b1, 8'h7E, 1'b0);
    step();
    check("bp_in_ready", {7'd0, in_ready}, 8'd0);
    expect_out("bp_pend", 1'b1, 4'hC, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("bp_3", 1'b1, 4'h3, 1'b0);
    step();
    expect_out("bp_7", 1'b1, 4'h7, 1'b1);
    step();
    expect_out("bp_e", 1'b1, 4'hE, 1'b0);
    step();
    check("bp_done", {7'd0, output_valid}, 8'd0);

    // Overrun: 11 held, 22 pending, FF dropped.
    drive(1'b1, 8'h11, 1'b0);
    step();
    drive(1'b1, 8'h22, 1'b0);
    step();
    drive(1'b1, 8'hFF, 1'b0);
    step();
    check("ovr_dropped", {7'd0, dropped}, 8'd1);
    drive(1'b0, 8'h00, 1'b1);
    expect_out("ovr_1h", 1'b1, 4'h1, 1'b1);
    step();
    expect_out("ovr_1l", 1'b1, 4'h1, 1'b0);
    step();
    expect_out("ovr_2h", 1'b1, 4'h2, 1'b1);
    step();
    expect_out("ovr_2l", 1'b1, 4'h2, 1'b0);
    step();
    check("ovr_done", {7'd0, output_valid}, 8'd0);

    // Reset while in LOW with pending valid.
    drive(1'b1, 8'h55, 1'b0);
    step();
    drive(1'b1, 8'h66, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    expect_out("rst_low", 1'b1, 4'h5, 1'b0);
    check("rst_pend", {7'd0, in_ready}, 8'd0);
    reset = 1'b1;
    step();
    expect_reset_state("rst_mid");
    reset = 1'b0;
    drive(1'b1, 8'h9B, 1'b1);
    step();
    expect_out("rst_9", 1'b1, 4'h9, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("rst_b", 1'b1, 4'hB, 1'b0);
    step();

    // LOW-completion race: 42 accepted as 81's low nibble leaves.
    drive(1'b1, 8'h81, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("race_1", 1'b1, 4'h1, 1'b0);
    drive(1'b1, 8'h42, 1'b1);
    step();
    expect_out("race_4", 1'b1, 4'h4, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("race_2", 1'b1, 4'h2, 1'b0);

    // Randomized traffic with occasional resets; model compares each cycle.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 70);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 6; c++) step();
    check("final_empty", {7'd0, output_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
